hi_fanin_collector: RTL and testbench
=====================================

Name: hi_fanin_collector

Overview:
Converging counterpart of the high-fanout broadcast structure. NUM_LANES single-bit sources, split across two hierarchical banks, are captured into one shadow register and serialized onto a single output net. Serialization uses a valid/ready handshake and ends with an even-parity trailer bit. The block is the many-drivers-to-one-load end of the same interface and serves as a resizer/repair_fanout-style test netlist with real sequential logic.

Parameters:
NUM_LANES, 70, total parallel source bits; must be even and >= 2.
BANK_SIZE, NUM_LANES/2, bits per capture bank; fixed at half of NUM_LANES.
CNT_W, $clog2(NUM_LANES), width of the shift index counter.

Ports:
clk1  input  1  sole clock; all state updates on the rising edge.
rst_n  input  1  synchronous active-low reset.
lanes_in  input  NUM_LANES  parallel source bits; bit 0 is serialized first.
cap_req  input  1  capture request; sampled only in IDLE.
cap_ack  output  1  one-cycle pulse on the cycle the capture occurs.
sout  output  1  serial data bit.
sout_valid  output  1  sout holds a valid bit.
sout_ready  input  1  sink accepts the bit when valid and ready are both 1.
sout_last  output  1  high with the parity trailer bit.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE; shadow register, counter and parity accumulator cleared; cap_ack, sout, sout_valid, sout_last and busy all 0. A reset in mid-frame aborts the frame immediately; no partial trailer is sent.
- States:
  - IDLE: cap_req=1 -> CAPTURE.
  - CAPTURE: exactly 1 cycle. Both banks register their lanes_in slice into the shadow register; cap_ack=1; counter=0; parity=0 -> SHIFT.
  - SHIFT: sout=shadow[counter]; sout_valid=1.
    - On handshake: parity ^= sout; if counter==NUM_LANES-1 -> PAR, else counter+1.
    - Without handshake: sout and counter hold stable. sout_valid never drops while waiting.
  - PAR: sout=parity (XOR of all NUM_LANES captured bits); sout_valid=1; sout_last=1.
    - On handshake -> IDLE.
- Latency: cap_req high in IDLE at edge N -> cap_ack high during cycle N+1 -> first sout_valid in cycle N+2.
- Frame length: NUM_LANES+1 accepted beats.
- Minimum frame time with sout_ready held at 1: NUM_LANES+3 cycles from request to return to IDLE.
- lanes_in changes after the capture edge do not affect the frame in flight.
- cap_req outside IDLE is ignored. It is not queued.
- cap_req held high continuously: a new frame starts on the cycle after PAR completes, i.e. back-to-back frames with one IDLE cycle between them.
- sout_ready while sout_valid=0 has no effect.
- Counter wrap: the counter never exceeds NUM_LANES-1. An out-of-range value is impossible by construction, and the FSM's default arm returns to IDLE.
- No combinational path from sout_ready to any output. All outputs are registered or decoded from registered state.

Decomposition:
- Package hi_fanin_pkg holds:
  - state enum {IDLE, CAPTURE, SHIFT, PAR} (2 bits);
  - NUM_LANES_DEFAULT=70;
  - function for CNT_W.
- One sub-module, hi_fanin_bank:
  - BANK_SIZE-wide register with a capture-enable;
  - instantiated twice, for lanes_in[BANK_SIZE-1:0] and lanes_in[NUM_LANES-1:BANK_SIZE];
  - keeps the hierarchical boundary so fan-in repair crosses module ports.

Test Plan:
1. Reset mid-SHIFT: assert rst_n=0 while counter=20 -> next cycle busy=0, sout_valid=0, sout_last=0, state IDLE; a subsequent cap_req yields a fresh frame starting from bit 0.
2. Basic frame: lanes_in=70'h2A_5555_5555_5555_5555 (bit0=1), sout_ready tied to 1, single-cycle cap_req -> cap_ack pulses once. The 70 sout beats match lanes_in LSB-first. The 71st beat has sout_last=1 and sout equal to XOR-reduce of lanes_in. busy is low 73 cycles after the request edge.
3. Backpressure: sout_ready toggles 1,0,0,1 repeatedly -> sout/sout_valid stay stable while stalled; no bit is dropped or duplicated; frame content is identical to scenario 2.
4. Input change after capture: lanes_in=all ones at capture, then switched to 0 one cycle later -> all 70 data beats = 1; parity beat = 0.
5. Request while busy, and continuous request: pulse cap_req during SHIFT -> ignored, only one cap_ack. With cap_req held at 1 throughout -> exactly one IDLE cycle between frames; each frame has 71 beats.
6. Bank boundary: lanes_in has only bit 34 and bit 35 set -> 1s appear on beats 34 and 35 (0-based), all other data beats 0, parity = 0.

Source files
------------

// File: rtl/hi_fanin_pkg.sv
// Shared types and sizing helpers for the high-fan-in serializer.
package hi_fanin_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SHIFT   = 2'd2,
        PAR     = 2'd3
    } state_t;

    localparam int NUM_LANES_DEFAULT = 70;

    // Width of an index that can address every lane (at least one bit).
    function automatic int cnt_width(input int lanes);
        return (lanes <= 1) ? 1 : $clog2(lanes);
    endfunction

endpackage

// File: rtl/hi_fanin_bank.sv
// One capture bank: a load-enabled register holding half of the parallel source lanes.
module hi_fanin_bank #(
    parameter int BANK_SIZE = 35
) (
    input  logic                 clk1,
    input  logic                 rst_n,
    input  logic                 capture,
    input  logic [BANK_SIZE-1:0] lanes,
    output logic [BANK_SIZE-1:0] bits
);

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            bits <= '0;
        end else if (capture) begin
            bits <= lanes;
        end
    end

endmodule

// File: rtl/hi_fanin_collector.sv
// Captures NUM_LANES source bits through two banks and serializes them LSB-first
// over a valid/ready link, closing each frame with an even-parity trailer beat.
module hi_fanin_collector
    import hi_fanin_pkg::*;
#(
    parameter int NUM_LANES = NUM_LANES_DEFAULT,
    parameter int BANK_SIZE = NUM_LANES / 2,
    parameter int CNT_W     = cnt_width(NUM_LANES)
) (
    input  logic                 clk1,
    input  logic                 rst_n,
    input  logic [NUM_LANES-1:0] lanes_in,
    input  logic                 cap_req,
    output logic                 cap_ack,
    output logic                 sout,
    output logic                 sout_valid,
    input  logic                 sout_ready,
    output logic                 sout_last,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_LANES - 1);

    state_t                   state;
    logic [CNT_W-1:0]         counter;
    logic                     parity;
    logic [NUM_LANES-1:0]     shadow;
    logic [BANK_SIZE-1:0]     bank_lo_bits;
    logic [NUM_LANES-BANK_SIZE-1:0] bank_hi_bits;
    logic                     capture;
    logic                     handshake;
    logic                     data_bit;

    // The banks load on the edge that ends the CAPTURE cycle.
    assign capture = (state == CAPTURE);

    hi_fanin_bank #(
        .BANK_SIZE(BANK_SIZE)
    ) u_bank_lo (
        .clk1   (clk1),
        .rst_n  (rst_n),
        .capture(capture),
        .lanes  (lanes_in[BANK_SIZE-1:0]),
        .bits   (bank_lo_bits)
    );

    hi_fanin_bank #(
        .BANK_SIZE(NUM_LANES - BANK_SIZE)
    ) u_bank_hi (
        .clk1   (clk1),
        .rst_n  (rst_n),
        .capture(capture),
        .lanes  (lanes_in[NUM_LANES-1:BANK_SIZE]),
        .bits   (bank_hi_bits)
    );

    assign shadow    = {bank_hi_bits, bank_lo_bits};
    assign data_bit  = shadow[counter];
    assign handshake = sout_valid & sout_ready;

    // Decoded purely from registers, so sout_ready never reaches an output.
    assign sout = sout_valid & (sout_last ? parity : data_bit);

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state      <= IDLE;
            counter    <= '0;
            parity     <= 1'b0;
            cap_ack    <= 1'b0;
            sout_valid <= 1'b0;
            sout_last  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            cap_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (cap_req) begin
                        state   <= CAPTURE;
                        cap_ack <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                CAPTURE: begin
                    state      <= SHIFT;
                    counter    <= '0;
                    parity     <= 1'b0;
                    sout_valid <= 1'b1;
                end
                SHIFT: begin
                    if (handshake) begin
                        parity <= parity ^ data_bit;
                        if (counter == LAST_IDX) begin
                            state     <= PAR;
                            sout_last <= 1'b1;
                        end else begin
                            counter <= counter + 1'b1;
                        end
                    end
                end
                PAR: begin
                    if (handshake) begin
                        state      <= IDLE;
                        sout_valid <= 1'b0;
                        sout_last  <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    counter    <= '0;
                    sout_valid <= 1'b0;
                    sout_last  <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hi_fanin_collector.sv
// Self-checking bench for hi_fanin_collector: directed table, corner sequences and
// randomized frames compared against a beat-list reference model.
module tb_hi_fanin_collector;

    localparam int NL = 70;

    logic          clk1;
    logic          rst_n;
    logic [NL-1:0] lanes_in;
    logic          cap_req;
    logic          cap_ack;
    logic          sout;
    logic          sout_valid;
    logic          sout_ready;
    logic          sout_last;
    logic          busy;

    int total_checks = 0;
    int pass_checks  = 0;

    hi_fanin_collector #(.NUM_LANES(NL)) dut (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .lanes_in  (lanes_in),
        .cap_req   (cap_req),
        .cap_ack   (cap_ack),
        .sout      (sout),
        .sout_valid(sout_valid),
        .sout_ready(sout_ready),
        .sout_last (sout_last),
        .busy      (busy)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    typedef struct {
        string         name;
        logic [NL-1:0] pat;
        int            mode;        // 0: ready=1, 1: 1,0,0,1 pattern, 2: random
        bit            clear_after;
        bit            extra_req;
        logic [NL-1:0] exp_data;
        logic          exp_par;
        int            exp_cycles;  // 0 = not checked
    } vec_t;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total_checks++;
        if (act === exp) pass_checks++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic logic rdy(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ((c % 4) == 0) || ((c % 4) == 3);
        return 1'($urandom_range(0, 1));
    endfunction

    // Reference: even parity is the XOR of all captured lanes.
    function automatic logic ref_parity(input logic [NL-1:0] p);
        int ones = 0;
        for (int i = 0; i < NL; i++) ones += int'(p[i]);
        return 1'(ones % 2);
    endfunction

    task automatic do_frame(input string nm, input logic [NL-1:0] pat, input logic [NL-1:0] exp_data,
                            input logic exp_par, input int mode, input bit clear_after,
                            input bit extra_req, input int exp_cycles);
        logic [NL-1:0] got;
        logic          got_par;
        int            beats, acks, c, last_err, stall_err;
        logic          pv, pr, ps, pl;
        bit            done;
        got = '0; got_par = 1'b0; beats = 0; acks = 0; c = 0;
        last_err = 0; stall_err = 0; pv = 0; pr = 0; ps = 0; pl = 0; done = 0;
        lanes_in   = pat;
        cap_req    = 1'b1;
        sout_ready = rdy(mode, 0);
        while (!done && c < 2000) begin
            @(negedge clk1);
            c++;
            cap_req = extra_req ? (c >= 10 && c < 12) : 1'b0;
            if (c == 1) begin
                check({nm, " cap_ack latency"}, cap_ack, 1);
                check({nm, " busy after req"}, busy, 1);
                check({nm, " no valid in capture"}, sout_valid, 0);
            end
            if (c == 2) check({nm, " first valid"}, sout_valid, 1);
            if (clear_after && c == 2) lanes_in = '0;
            if (cap_ack) acks++;
            if (pv && !pr && (!sout_valid || sout !== ps || sout_last !== pl)) stall_err++;
            sout_ready = rdy(mode, c);
            if (sout_valid && sout_ready) begin
                if (beats < NL) begin
                    got[beats] = sout;
                    if (sout_last) last_err++;
                end else begin
                    got_par = sout;
                    if (!sout_last) last_err++;
                    done = 1;
                end
                beats++;
            end
            pv = sout_valid; pr = sout_ready; ps = sout; pl = sout_last;
        end
        check({nm, " completed"}, done, 1);
        @(negedge clk1);
        c++;
        sout_ready = 1'b0;
        check({nm, " busy low at end"}, busy, 0);
        check({nm, " valid low at end"}, sout_valid, 0);
        if (exp_cycles > 0) check({nm, " frame cycles"}, c, exp_cycles);
        check({nm, " cap_ack count"}, acks, 1);
        check({nm, " beat count"}, beats, NL + 1);
        check({nm, " data beats"}, got, exp_data);
        check({nm, " parity beat"}, got_par, exp_par);
        check({nm, " last flag placement"}, last_err, 0);
        check({nm, " stall stability"}, stall_err, 0);
    endtask

    vec_t vecs[7];

    initial begin
        logic [NL-1:0] p2;
        logic [95:0]   r;
        int            c, fi, idle_between, ack2_c;
        int            bf[2];
        bit            done;

        p2 = 70'h2A_5555_5555_5555_5555;
        vecs[0] = '{"basic",       p2, 0, 0, 0, p2, 1'b1, NL + 3};
        vecs[1] = '{"backpress",   p2, 1, 0, 0, p2, 1'b1, 0};
        vecs[2] = '{"late change", {NL{1'b1}}, 0, 1, 0, {NL{1'b1}}, 1'b0, NL + 3};
        vecs[3] = '{"req in shift", 70'h3F_0123_4567_89AB_CDEF, 0, 0, 1,
                    70'h3F_0123_4567_89AB_CDEF, 1'b0, NL + 3};
        vecs[4] = '{"bank edge",   70'h00_0000_000C_0000_0000, 0, 0, 0,
                    70'h00_0000_000C_0000_0000, 1'b0, NL + 3};
        vecs[5] = '{"all zero",    '0, 1, 0, 0, '0, 1'b0, 0};
        vecs[6] = '{"top bit",     70'h20_0000_0000_0000_0000, 1, 0, 0,
                    70'h20_0000_0000_0000_0000, 1'b1, 0};

        rst_n = 1'b0; cap_req = 1'b0; sout_ready = 1'b0; lanes_in = '0;
        repeat (3) @(negedge clk1);
        check("reset busy", busy, 0);
        check("reset valid", sout_valid, 0);
        check("reset last", sout_last, 0);
        check("reset ack", cap_ack, 0);
        check("reset sout", sout, 0);
        rst_n = 1'b1;
        @(negedge clk1);

        foreach (vecs[i])
            do_frame(vecs[i].name, vecs[i].pat, vecs[i].exp_data, vecs[i].exp_par,
                     vecs[i].mode, vecs[i].clear_after, vecs[i].extra_req, vecs[i].exp_cycles);

        // Reset while the counter sits at 20.
        lanes_in = 70'h15_AAAA_AAAA_AAAA_AAAA;
        cap_req = 1'b1; sout_ready = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk1);
            cap_req = 1'b0;
        end
        check("mid-frame valid before reset", sout_valid, 1);
        rst_n = 1'b0;
        @(negedge clk1);
        check("abort busy", busy, 0);
        check("abort valid", sout_valid, 0);
        check("abort last", sout_last, 0);
        rst_n = 1'b1; sout_ready = 1'b0;
        @(negedge clk1);
        do_frame("post-reset", p2, p2, ref_parity(p2), 0, 0, 0, NL + 3);

        // Continuous request: back-to-back frames separated by one IDLE cycle.
        lanes_in = p2; cap_req = 1'b1; sout_ready = 1'b1;
        c = 0; fi = -1; idle_between = 0; ack2_c = 0; bf[0] = 0; bf[1] = 0; done = 0;
        while (!done && c < 500) begin
            @(negedge clk1);
            c++;
            if (cap_ack) begin
                fi++;
                if (fi == 1) begin
                    ack2_c = c;
                    cap_req = 1'b0;
                end
            end
            if (fi == 0 && !busy) idle_between++;
            if (fi >= 0 && fi < 2 && sout_valid && sout_ready) bf[fi]++;
            if (fi >= 1 && sout_valid && sout_last) done = 1;
        end
        check("continuous completed", done, 1);
        @(negedge clk1);
        sout_ready = 1'b0;
        check("continuous idle cycles", idle_between, 1);
        check("continuous second ack cycle", ack2_c, NL + 4);
        check("continuous frame0 beats", bf[0], NL + 1);
        check("continuous frame1 beats", bf[1], NL + 1);
        check("continuous ends idle", busy, 0);
        @(negedge clk1);

        // Randomized frames against the reference model.
        for (int i = 0; i < 6; i++) begin
            r = {$urandom, $urandom, $urandom};
            do_frame($sformatf("random%0d", i), r[NL-1:0], r[NL-1:0], ref_parity(r[NL-1:0]),
                     i % 3, 0, 0, (i % 3 == 0) ? NL + 3 : 0);
            repeat ($urandom_range(0, 3)) @(negedge clk1);
        end

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
